// File: rtl/dmrs_port_rotator.sv
// rtl/dmrs_port_rotator.sv - multi-port DMRS cyclic-shift / OCC rotator with backpressure
//
// Takes one base low-PAPR sample per handshake and emits NUM_PORTS rotated
// copies in parallel. Port p multiplies by e^{j*2*pi*cs_p*n/12} and, when its
// OCC bit is set, by (-1)^n. Three-stage pipeline, 1 sample/cycle, global stall.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_cs, cfg_occ       per-port cyclic shift (4 bits each) and OCC enable,
//                         latched on an accepted sof sample
//   in_valid/in_ready     input handshake; in_sof/in_last framing; in_re/in_im
//   out_valid/out_ready   output handshake; out_re/out_im lanes (port p at
//                         [DW*(p+1)-1:DW*p]); out_sof/out_last/out_idx framing
//   cfg_err               sticky flag: a cs value of 12..15 was latched
module dmrs_port_rotator #(
    parameter int DW        = 9,
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4*NUM_PORTS-1:0]   cfg_cs,
    input  logic [NUM_PORTS-1:0]     cfg_occ,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic                     in_last,
    input  logic [DW-1:0]            in_re,
    input  logic [DW-1:0]            in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW*NUM_PORTS-1:0]  out_re,
    output logic [DW*NUM_PORTS-1:0]  out_im,
    output logic                     out_sof,
    output logic                     out_last,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     cfg_err
);
    localparam int PW = DW + 11;
    localparam int SW = DW + 12;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (DW - 1)));
    localparam logic signed [SW-1:0] HALF    = SW'(256);

    // Twiddle table, 1.0 = 512, angle = 30 degrees * k.
    function automatic logic signed [10:0] tw_cos(input logic [3:0] k);
        case (k)
            4'd0:    return 11'sd512;
            4'd1:    return 11'sd443;
            4'd2:    return 11'sd256;
            4'd3:    return 11'sd0;
            4'd4:    return -11'sd256;
            4'd5:    return -11'sd443;
            4'd6:    return -11'sd512;
            4'd7:    return -11'sd443;
            4'd8:    return -11'sd256;
            4'd9:    return 11'sd0;
            4'd10:   return 11'sd256;
            4'd11:   return 11'sd443;
            default: return 11'sd512;
        endcase
    endfunction

    function automatic logic signed [10:0] tw_sin(input logic [3:0] k);
        case (k)
            4'd0:    return 11'sd0;
            4'd1:    return 11'sd256;
            4'd2:    return 11'sd443;
            4'd3:    return 11'sd512;
            4'd4:    return 11'sd443;
            4'd5:    return 11'sd256;
            4'd6:    return 11'sd0;
            4'd7:    return -11'sd256;
            4'd8:    return -11'sd443;
            4'd9:    return -11'sd512;
            4'd10:   return -11'sd443;
            4'd11:   return -11'sd256;
            default: return 11'sd0;
        endcase
    endfunction

    // Optional OCC negation, round half up, then clamp to the lane range.
    function automatic logic [DW-1:0] round_sat(input logic signed [SW-1:0] v, input logic neg);
        logic signed [SW-1:0] x;
        x = neg ? -v : v;
        x = (x + HALF) >>> 9;
        if (x > SAT_MAX)      return SAT_MAX[DW-1:0];
        else if (x < SAT_MIN) return SAT_MIN[DW-1:0];
        else                  return x[DW-1:0];
    endfunction

    logic stall;
    logic accept;

    // Per-symbol state: index and phase of the next sample, latched config.
    logic [IDX_W-1:0]     n_cnt;
    logic [3:0]           k_cnt  [NUM_PORTS];
    logic [3:0]           cs_lat [NUM_PORTS];
    logic [NUM_PORTS-1:0] occ_lat;

    // Values that apply to the sample currently offered (sof restarts them).
    logic [IDX_W-1:0]     n_use;
    logic [NUM_PORTS-1:0] occ_use;
    logic [3:0]           cs_use [NUM_PORTS];
    logic [3:0]           k_use  [NUM_PORTS];
    logic [4:0]           k_sum  [NUM_PORTS];
    logic [3:0]           k_next [NUM_PORTS];
    logic                 cs_bad;

    logic                    s1_valid, s1_sof, s1_last;
    logic signed [DW-1:0]    s1_re, s1_im;
    logic [3:0]              s1_k [NUM_PORTS];
    logic [NUM_PORTS-1:0]    s1_neg;
    logic [IDX_W-1:0]        s1_idx;

    logic                    s2_valid, s2_sof, s2_last;
    logic signed [PW-1:0]    s2_rc [NUM_PORTS];
    logic signed [PW-1:0]    s2_is [NUM_PORTS];
    logic signed [PW-1:0]    s2_rs [NUM_PORTS];
    logic signed [PW-1:0]    s2_ic [NUM_PORTS];
    logic [NUM_PORTS-1:0]    s2_neg;
    logic [IDX_W-1:0]        s2_idx;

    logic [DW-1:0]           res_re [NUM_PORTS];
    logic [DW-1:0]           res_im [NUM_PORTS];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    always_comb begin
        n_use   = in_sof ? '0 : n_cnt;
        occ_use = in_sof ? cfg_occ : occ_lat;
        cs_bad  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cs_use[p] = cs_lat[p];
            k_use[p]  = k_cnt[p];
            if (in_sof) begin
                k_use[p] = 4'd0;
                if (cfg_cs[4*p +: 4] >= 4'd12) begin
                    cs_use[p] = 4'd0;
                    cs_bad    = 1'b1;
                end else begin
                    cs_use[p] = cfg_cs[4*p +: 4];
                end
            end
            // Both terms are below 12, so one conditional subtract is a full mod 12.
            k_sum[p]  = 5'(k_use[p]) + 5'(cs_use[p]);
            k_next[p] = (k_sum[p] >= 5'd12) ? 4'(k_sum[p] - 5'd12) : k_sum[p][3:0];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            res_re[p] = round_sat(SW'(s2_rc[p]) - SW'(s2_is[p]), s2_neg[p]);
            res_im[p] = round_sat(SW'(s2_rs[p]) + SW'(s2_ic[p]), s2_neg[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_cnt     <= '0;
            occ_lat   <= '0;
            cfg_err   <= 1'b0;
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_last   <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_neg    <= '0;
            s1_idx    <= '0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_last   <= 1'b0;
            s2_neg    <= '0;
            s2_idx    <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_re    <= '0;
            out_im    <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                k_cnt[p]  <= 4'd0;
                cs_lat[p] <= 4'd0;
                s1_k[p]   <= 4'd0;
                s2_rc[p]  <= '0;
                s2_is[p]  <= '0;
                s2_rs[p]  <= '0;
                s2_ic[p]  <= '0;
            end
        end else begin
            if (accept) begin
                n_cnt   <= n_use + IDX_W'(1);
                occ_lat <= occ_use;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    cs_lat[p] <= cs_use[p];
                    k_cnt[p]  <= k_next[p];
                end
                if (in_sof && cs_bad) cfg_err <= 1'b1;
            end

            // Whole pipeline advances together; empty slots travel as bubbles.
            if (!stall) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_re   <= in_re;
                    s1_im   <= in_im;
                    s1_neg  <= occ_use & {NUM_PORTS{n_use[0]}};
                    s1_idx  <= n_use;
                    s1_sof  <= in_sof;
                    s1_last <= in_last;
                    for (int p = 0; p < NUM_PORTS; p++) s1_k[p] <= k_use[p];
                end

                s2_valid <= s1_valid;
                s2_neg   <= s1_neg;
                s2_idx   <= s1_idx;
                s2_sof   <= s1_sof;
                s2_last  <= s1_last;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    s2_rc[p] <= PW'(s1_re) * PW'(tw_cos(s1_k[p]));
                    s2_is[p] <= PW'(s1_im) * PW'(tw_sin(s1_k[p]));
                    s2_rs[p] <= PW'(s1_re) * PW'(tw_sin(s1_k[p]));
                    s2_ic[p] <= PW'(s1_im) * PW'(tw_cos(s1_k[p]));
                end

                out_valid <= s2_valid;
                out_sof   <= s2_sof;
                out_last  <= s2_last;
                out_idx   <= s2_idx;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    out_re[DW*p +: DW] <= res_re[p];
                    out_im[DW*p +: DW] <= res_im[p];
                end
            end
        end
    end
endmodule
